// File: rtl/mul_div_pkg.sv
// mul_div_pkg: op-bit indices, FSM states and reset values shared by the mul/div unit.
package mul_div_pkg;
  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;
  localparam int MD_MTHI  = 4;
  localparam int MD_MTLO  = 5;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [31:0] HI_RST = 32'h0;
  localparam logic [31:0] LO_RST = 32'h0;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_e;
endpackage

// File: rtl/mul_div_div_iter.sv
// div_iter: one restoring-division step on the packed {remainder, quotient} pair.
module div_iter (
  input  logic [63:0] rq_i,
  input  logic [31:0] dvs_i,
  output logic [63:0] rq_o
);
  logic [32:0] top, diff;
  // top keeps the bit shifted out of the remainder so the trial subtract never overflows
  assign top  = rq_i[63:31];
  assign diff = top - {1'b0, dvs_i};
  assign rq_o = {diff[32] ? top[31:0] : diff[31:0], rq_i[30:0], ~diff[32]};
endmodule

// File: rtl/mul_div.sv
// mul_div: MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO and a busy/done handshake.
module mul_div
  import mul_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid_in,
  input  logic [5:0]  md_op_in,
  input  logic [31:0] md_src0_in,
  input  logic [31:0] md_src1_in,
  input  logic        md_cancel_in,
  output logic        md_busy_out,
  output logic        md_done_out,
  output logic [31:0] md_hi_out,
  output logic [31:0] md_lo_out
);
  md_state_e        state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, src0_q, src0_d;
  logic [63:0]      acc_q, acc_d, step, prod;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nq_q, nq_d, nr_q, nr_d, dz_q, dz_d;
  logic             start, is_mul, is_div, msg, dvd_neg, dvs_neg;
  logic [31:0]      quo_fix, rem_fix;
  assign start   = md_valid_in && md_op_in != 6'd0 && (md_op_in & (md_op_in - 6'd1)) == 6'd0;
  assign is_mul  = md_op_in[MD_MULT] | md_op_in[MD_MULTU];
  assign is_div  = md_op_in[MD_DIV] | md_op_in[MD_DIVU];
  assign msg     = md_op_in[MD_MULT];
  assign dvd_neg = md_op_in[MD_DIV] & md_src0_in[31];
  assign dvs_neg = md_op_in[MD_DIV] & md_src1_in[31];
  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU
  assign prod    = {{32{msg & md_src0_in[31]}}, md_src0_in} * {{32{msg & md_src1_in[31]}}, md_src1_in};
  assign quo_fix = dz_q ? 32'hFFFF_FFFF : (nq_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem_fix = dz_q ? src0_q : (nr_q ? -acc_q[63:32] : acc_q[63:32]);
  div_iter u_div_iter (.rq_i(acc_q), .dvs_i(dvs_q), .rq_o(step));
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    src0_d  = src0_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dz_d    = dz_q;
    if (md_cancel_in) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (start) begin
        hi_d = md_op_in[MD_MTHI] ? md_src0_in : hi_q;
        lo_d = md_op_in[MD_MTLO] ? md_src0_in : lo_q;
        if (is_mul) begin
          acc_d   = prod;
          state_d = S_MUL;
        end
        if (is_div) begin
          acc_d   = {32'h0, dvd_neg ? -md_src0_in : md_src0_in};
          dvs_d   = dvs_neg ? -md_src1_in : md_src1_in;
          src0_d  = md_src0_in;
          cnt_d   = '0;
          nq_d    = dvd_neg ^ dvs_neg;
          nr_d    = dvd_neg;
          dz_d    = md_src1_in == 32'h0;
          state_d = S_DIV;
        end
      end
      S_MUL: begin
        hi_d    = acc_q[63:32];
        lo_d    = acc_q[31:0];
        state_d = S_IDLE;
      end
      S_DIV: begin
        acc_d   = step;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(DIV_CYCLES - 1) ? S_FIX : S_DIV;
      end
      S_FIX: begin
        hi_d    = rem_fix;
        lo_d    = quo_fix;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= HI_RST;
      lo_q    <= LO_RST;
      acc_q   <= '0;
      dvs_q   <= '0;
      src0_q  <= '0;
      cnt_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      src0_q  <= src0_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dz_q    <= dz_d;
    end
  end
  assign md_busy_out = state_q != S_IDLE;
  assign md_done_out = (state_q == S_MUL || state_q == S_FIX) && !md_cancel_in;
  assign md_hi_out   = hi_q;
  assign md_lo_out   = lo_q;
endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: directed vectors; a negedge monitor scores HI/LO, busy length and done against a queue.
module tb_mul_div;
  logic        clk = 1'b0;
  logic        rst, md_valid_in, md_cancel_in, md_busy_out, md_done_out;
  logic [5:0]  md_op_in;
  logic [31:0] md_src0_in, md_src1_in, md_hi_out, md_lo_out;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    bit          done;
  } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   blen = 0;
  bit   sdone = 0, bq = 0;
  localparam logic [5:0] OP_MULT = 6'h01, OP_MULTU = 6'h02, OP_DIV = 6'h04,
                         OP_DIVU = 6'h08, OP_MTHI = 6'h10, OP_MTLO = 6'h20;
  mul_div dut (
    .clk(clk), .rst(rst), .md_valid_in(md_valid_in), .md_op_in(md_op_in),
    .md_src0_in(md_src0_in), .md_src1_in(md_src1_in), .md_cancel_in(md_cancel_in),
    .md_busy_out(md_busy_out), .md_done_out(md_done_out),
    .md_hi_out(md_hi_out), .md_lo_out(md_lo_out)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (md_valid_in) begin
      n_chk++;
      if (md_busy_out) begin
        n_fail++;
        $display("FAIL protocol: md_valid_in while busy");
      end
    end
    if (md_busy_out) begin
      blen++;
      if (md_done_out) sdone = 1;
    end else if (bq) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: unexpected op completion");
      end else begin
        e = exp_q.pop_front();
        chk("hi", md_hi_out, e.hi);
        chk("lo", md_lo_out, e.lo);
        chk("busy_len", blen, e.len);
        chk("done_seen", 32'(sdone), 32'(e.done));
      end
      blen  = 0;
      sdone = 0;
    end
    bq = md_busy_out;
  end
  task automatic issue(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    md_valid_in = 1'b1;
    md_op_in    = op;
    md_src0_in  = a;
    md_src1_in  = b;
    @(posedge clk); #1;
    md_valid_in = 1'b0;
    md_op_in    = 6'h0;
  endtask
  task automatic run(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] hi, logic [31:0] lo, int len);
    int n = 0;
    exp_q.push_back('{hi: hi, lo: lo, len: len, done: 1'b1});
    issue(op, a, b);
    while (md_busy_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (md_busy_out) chk("busy_timeout", 32'(md_busy_out), 32'h0);
    @(posedge clk); #1;
  endtask
  task automatic abort_after10(bit use_rst, logic [31:0] hi, logic [31:0] lo);
    exp_q.push_back('{hi: hi, lo: lo, len: 10, done: 1'b0});
    issue(OP_DIV, 32'd50, 32'd5);
    repeat (9) begin
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1;
    else md_cancel_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    md_cancel_in = 1'b0;
    chk("abort_busy", 32'(md_busy_out), 32'h0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; md_valid_in = 1'b0; md_cancel_in = 1'b0;
    md_op_in = 6'h0; md_src0_in = 32'h0; md_src1_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hi", md_hi_out, 32'h0);
    chk("rst_lo", md_lo_out, 32'h0);
    chk("rst_busy", 32'(md_busy_out), 32'h0);
    chk("rst_done", 32'(md_done_out), 32'h0);
    run(OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    run(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 33);
    run(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33);
    run(OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
    run(OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 33);
    run(OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33);
    run(OP_DIVU,  32'hFFFF_FFF9, 32'd2,        32'd1,         32'h7FFF_FFFC, 33);
    md_valid_in = 1'b1; md_op_in = OP_MTHI; md_src0_in = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mthi_hi", md_hi_out, 32'h1234_5678);
    chk("mthi_busy", 32'(md_busy_out), 32'h0);
    md_op_in = OP_MTLO; md_src0_in = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    md_valid_in = 1'b0; md_op_in = 6'h0;
    chk("mtlo_lo", md_lo_out, 32'h9ABC_DEF0);
    chk("mtlo_hi", md_hi_out, 32'h1234_5678);
    chk("mtlo_busy", 32'(md_busy_out), 32'h0);
    md_cancel_in = 1'b1;
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    md_cancel_in = 1'b0;
    chk("cancel_idle_hi", md_hi_out, 32'h1234_5678);
    issue(6'h0, 32'h5, 32'h5);
    chk("zero_op_busy", 32'(md_busy_out), 32'h0);
    issue(OP_MTHI | OP_MTLO, 32'h5, 32'h5);
    chk("multi_op_hi", md_hi_out, 32'h1234_5678);
    chk("multi_op_lo", md_lo_out, 32'h9ABC_DEF0);
    issue(OP_MTHI, 32'hA, 32'h0);
    issue(OP_MTLO, 32'hB, 32'h0);
    abort_after10(1'b0, 32'hA, 32'hB);
    abort_after10(1'b1, 32'h0, 32'h0);
    chk("post_rst_hi", md_hi_out, 32'h0);
    run(OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1);
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
